// File: rtl/filter_pkg.sv
// Shared types and helpers for the RGB filter frame sequencer.
// Holds the FSM state type and counter width helpers.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_COL_W = clog2(DEF_IMG_W);
  localparam int DEF_ROW_W = clog2(DEF_IMG_H);

endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel counter: linear address plus col/row.
// Returns to zero after the last pixel or on clr.
module raster_counter
  import filter_pkg::*;
#(
  parameter int W      = DEF_IMG_W,
  parameter int H      = DEF_IMG_H,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  output logic [ADDR_W-1:0]   addr,
  output logic [clog2(W)-1:0] col,
  output logic [clog2(H)-1:0] row,
  output logic                last
);

  localparam int CW = clog2(W);
  localparam int RW = clog2(H);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              col_end;

  assign col_end = (col_q == CW'(W - 1));
  assign last    = col_end && (row_q == RW'(H - 1));
  assign addr    = addr_q;
  assign col     = col_q;
  assign row     = row_q;

  // Next position: step in raster order, wrap col into the next row.
  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (clr || (en && last)) begin
      addr_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (en) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Frame sequencer for the three-channel Sobel filter datapath.
// Streams a frame in, then writes filtered pixels KERN_LAT later.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int KERN_LAT = 259
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              pix_valid_o,
  output logic              frame_end_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              border_o
);

  localparam int CW  = clog2(IMG_W);
  localparam int RW  = clog2(IMG_H);
  localparam int TOT = MEM_LAT + KERN_LAT;
  localparam int LW  = clog2(TOT);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] fe_q, fe_d;
  logic               lat_act_q, lat_act_d;
  logic [LW-1:0]      lat_cnt_q, lat_cnt_d;

  logic              start_go, rd_end, wr_end, lat_fire;
  logic              cnt_clr;
  logic              rd_last, wr_last;
  logic [CW-1:0]     rd_col, wr_col;
  logic [RW-1:0]     rd_row, wr_row;
  logic              unused_rd_pos;

  assign start_go = (state_q == IDLE) && start_i;
  assign rd_end   = rd_en_q && rd_last;
  assign wr_end   = wr_en_q && wr_last;
  assign lat_fire = lat_act_q && (lat_cnt_q == LW'(TOT - 1));
  assign cnt_clr  = (state_q == IDLE);

  raster_counter #(
    .W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (rd_en_q),
    .addr (rd_addr_o),
    .col  (rd_col),
    .row  (rd_row),
    .last (rd_last)
  );

  raster_counter #(
    .W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (wr_en_q),
    .addr (wr_addr_o),
    .col  (wr_col),
    .row  (wr_row),
    .last (wr_last)
  );

  assign unused_rd_pos = ^{rd_col, rd_row};

  // FSM, read/write strobes, latency counter and valid delay.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    lat_act_d = lat_act_q;
    lat_cnt_d = lat_cnt_q;
    vld_d     = vld_q << 1;
    fe_d      = fe_q << 1;
    vld_d[0]  = rd_en_q;
    fe_d[0]   = rd_end;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (rd_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_end) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_go) rd_en_d = 1'b1;
    else if (rd_end) rd_en_d = 1'b0;

    // Write stream begins TOT cycles after the start sample.
    if (start_go) begin
      lat_act_d = 1'b1;
      lat_cnt_d = '0;
    end else if (lat_fire) begin
      lat_act_d = 1'b0;
      lat_cnt_d = '0;
    end else if (lat_act_q) begin
      lat_cnt_d = lat_cnt_q + LW'(1);
    end

    if (lat_fire) wr_en_d = 1'b1;
    else if (wr_end) wr_en_d = 1'b0;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      vld_q     <= '0;
      fe_q      <= '0;
      lat_act_q <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      vld_q     <= vld_d;
      fe_q      <= fe_d;
      lat_act_q <= lat_act_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign pix_valid_o = vld_q[MEM_LAT-1];
  assign frame_end_o = fe_q[MEM_LAT-1];
  assign wr_en_o     = wr_en_q;
  assign border_o    = wr_en_q && (
                         (wr_col == '0) ||
                         (wr_col == CW'(IMG_W - 1)) ||
                         (wr_row == '0) ||
                         (wr_row == RW'(IMG_H - 1)));

endmodule

// File: tb/tb_filter_ctrl.sv
// Scoreboard bench for filter_ctrl on a 4x3 frame.
// Runs MEM_LAT=1 and MEM_LAT=3 instances through directed cases.
module tb_filter_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 16;
  localparam int KL = 6;
  localparam int N  = W * H;

  typedef struct {
    int   cyc;
    int   addr;
    logic b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic sel = 1'b0;

  logic [1:0] busy, done, rd_en, pv, fe, wr_en, border;
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] wr_addr [2];

  always #5 clk = ~clk;

  filter_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW),
    .MEM_LAT(1), .KERN_LAT(KL)
  ) dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
    .busy_o(busy[0]), .done_o(done[0]),
    .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]),
    .pix_valid_o(pv[0]), .frame_end_o(fe[0]),
    .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]),
    .border_o(border[0])
  );

  filter_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW),
    .MEM_LAT(3), .KERN_LAT(KL)
  ) dut3 (
    .clk(clk), .rst(rst), .start_i(start3),
    .busy_o(busy[1]), .done_o(done[1]),
    .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]),
    .pix_valid_o(pv[1]), .frame_end_o(fe[1]),
    .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]),
    .border_o(border[1])
  );

  int total = 0;
  int bad = 0;
  int ec = -1;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  pv_q[$];
  int  fe_q[$];
  int  dn_q[$];
  int  fr_t0[$];
  int  fr_ml[$];

  logic [N-1:0] btab = 12'b1111_1001_1111;

  always @(posedge clk) ec++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=1 exp=0 t=%0t", nm, $time);
  endtask

  task automatic push_frame(input int t0, input int ml);
    for (int i = 0; i < N; i++) begin
      rd_q.push_back('{t0 + 1 + i, i, 1'b0});
      pv_q.push_back(t0 + 1 + ml + i);
      wr_q.push_back('{t0 + 1 + ml + KL + i, i, btab[i]});
    end
    fe_q.push_back(t0 + N + ml);
    dn_q.push_back(t0 + N + ml + KL + 1);
    fr_t0.push_back(t0);
    fr_ml.push_back(ml);
  endtask

  function automatic bit sb_empty();
    return rd_q.size() == 0 && wr_q.size() == 0 &&
           pv_q.size() == 0 && fe_q.size() == 0 &&
           dn_q.size() == 0;
  endfunction

  task automatic flush();
    rd_q.delete();
    wr_q.delete();
    pv_q.delete();
    fe_q.delete();
    dn_q.delete();
    fr_t0.delete();
    fr_ml.delete();
  endtask

  // Pulse start so that it is sampled at edge index e (or next edge).
  task automatic pulse_at(input int e, input bit which, output int t0);
    @(negedge clk);
    while (ec + 1 < e) @(negedge clk);
    t0 = ec + 1;
    if (which) start3 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (!sb_empty() && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(nm, int'(sb_empty()), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm, input int k);
    chk(nm, int'({busy[k], done[k], rd_en[k], pv[k],
                  fe[k], wr_en[k], border[k]}), 0);
    chk({nm, "_addr"}, int'(rd_addr[k]) + int'(wr_addr[k]), 0);
  endtask

  // Monitor: pop and compare whenever the DUT presents an event.
  int  cur;
  bit  exp_b;
  ev_t e;
  int  c;
  always @(negedge clk) begin
    cur = ec + 1;
    if (rd_en[sel]) begin
      if (rd_q.size() == 0) unexp("rd_unexp");
      else begin
        e = rd_q.pop_front();
        chk("rd_cyc", cur, e.cyc);
        chk("rd_addr", int'(rd_addr[sel]), e.addr);
      end
    end
    if (pv[sel]) begin
      if (pv_q.size() == 0) unexp("pv_unexp");
      else begin
        c = pv_q.pop_front();
        chk("pv_cyc", cur, c);
      end
    end
    if (fe[sel]) begin
      if (fe_q.size() == 0) unexp("fe_unexp");
      else begin
        c = fe_q.pop_front();
        chk("fe_cyc", cur, c);
      end
    end
    if (wr_en[sel]) begin
      if (wr_q.size() == 0) unexp("wr_unexp");
      else begin
        e = wr_q.pop_front();
        chk("wr_cyc", cur, e.cyc);
        chk("wr_addr", int'(wr_addr[sel]), e.addr);
        chk("border", int'(border[sel]), int'(e.b));
      end
    end else begin
      chk("idle_wr", int'(border[sel]) + int'(wr_addr[sel]), 0);
    end
    if (done[sel]) begin
      if (dn_q.size() == 0) unexp("done_unexp");
      else begin
        c = dn_q.pop_front();
        chk("done_cyc", cur, c);
      end
    end
    exp_b = 1'b0;
    foreach (fr_t0[k])
      if (cur >= fr_t0[k] + 1 &&
          cur <= fr_t0[k] + N + fr_ml[k] + KL)
        exp_b = 1'b1;
    chk("busy", int'(busy[sel]), int'(exp_b));
  end

  int t0, td;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst1", 0);
    chk_zero("rst3", 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: timing and border flags.
    pulse_at(0, 1'b0, t0);
    push_frame(t0, 1);
    drain("t1_drain");

    // Start pulses while busy are ignored.
    pulse_at(0, 1'b0, t0);
    push_frame(t0, 1);
    pulse_at(t0 + 5, 1'b0, td);
    pulse_at(t0 + 15, 1'b0, td);
    drain("t3_drain");

    // Start held high: back-to-back frames.
    @(negedge clk);
    t0 = ec + 1;
    start1 = 1'b1;
    push_frame(t0, 1);
    push_frame(t0 + 21, 1);
    while (ec + 1 < t0 + 30) @(negedge clk);
    start1 = 1'b0;
    drain("t4_drain");

    // Asynchronous reset mid-frame.
    pulse_at(0, 1'b0, t0);
    push_frame(t0, 1);
    while (ec < t0 + 9) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b0;
    #1;
    chk_zero("mid_rst", 0);
    flush();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pulse_at(0, 1'b0, t0);
    push_frame(t0, 1);
    drain("t5_drain");

    // Longer source memory latency.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    pulse_at(0, 1'b1, t0);
    push_frame(t0, 3);
    drain("t6_drain");

    chk("sb_left", rd_q.size() + wr_q.size() +
        pv_q.size() + fe_q.size() + dn_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
